// File: rtl/nibble_serial_sub.sv
// Nibble-serial two's-complement subtractor: one 4-bit lookahead group per clock, LSB group first.
// Optional build macro SUB_SAT_EN saturates diff on signed overflow instead of wrapping.
module nibble_serial_sub #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] min_a,
  input  logic [DATA_W-1:0] sub_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              borrow_out,
  output logic              ovf
);

  localparam int NG   = DATA_W / 4;
  localparam int IW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int LAST = NG - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     grp;
  logic              carry_p1;
  logic              a_msb;
  logic              b_msb;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] nb_p0;
  logic [DATA_W-5:0] acc_p1;

  logic              accept;
  logic [4:0]        gsum;
  logic [DATA_W-1:0] raw;
  logic              ovf_c;

  // 4-bit carry-lookahead adder: returns {carry_out, sum}.
  function automatic logic [4:0] grp_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

`ifdef SUB_SAT_EN
  function automatic logic [DATA_W-1:0] sat_fn(input logic [DATA_W-1:0] r,
                                               input logic of, input logic a_sign);
    if (!of)
      return r;
    return a_sign ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
`endif

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Operands are shifted right each RUN cycle so the active group always sits in bits [3:0];
  // finished group sums enter the accumulator from the top.
  assign gsum  = grp_add(a_p0[3:0], nb_p0[3:0], carry_p1);
  assign raw   = {gsum[3:0], acc_p1};
  assign ovf_c = (a_msb != b_msb) & (raw[DATA_W-1] != a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      grp        <= '0;
    end else if (accept) begin
      a_p0      <= min_a;
      nb_p0     <= ~sub_b;
      a_msb     <= min_a[DATA_W-1];
      b_msb     <= sub_b[DATA_W-1];
      carry_p1  <= 1'b1;
      grp       <= '0;
      out_valid <= 1'b0;
      state     <= RUN;
    end else begin
      case (state)
        RUN: begin
          a_p0     <= a_p0 >> 4;
          nb_p0    <= nb_p0 >> 4;
          acc_p1   <= raw[DATA_W-1:4];
          carry_p1 <= gsum[4];
          grp      <= grp + 1'b1;
          if (grp == IW'(LAST)) begin
`ifdef SUB_SAT_EN
            diff <= sat_fn(raw, ovf_c, a_msb);
`else
            diff <= raw;
`endif
            borrow_out <= ~gsum[4];
            ovf        <= ovf_c;
            out_valid  <= 1'b1;
            grp        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub: driver pushes expected results, negedge monitor pops them.
module tb_nibble_serial_sub;
  localparam int DW = 16;
  localparam int NG = DW / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] min_a;
  logic [DW-1:0] sub_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] diff;
  logic          borrow_out;
  logic          ovf;

  nibble_serial_sub #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .min_a(min_a), .sub_b(sub_b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          bo;
    logic          ov;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   or_mode = 1;  // 0: random out_ready, 1: held high, 2: held low
  logic ov_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov; e.acc = 0;
    return e;
  endfunction

  // Reference: plain integer subtraction plus the overflow/borrow rules.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int unsigned ua, ub;
    ua   = a;
    ub   = b;
    e.d  = DW'(ua - ub);
    e.bo = (ua < ub);
    e.ov = (a[DW-1] != b[DW-1]) && (e.d[DW-1] != a[DW-1]);
`ifdef SUB_SAT_EN
    if (e.ov) e.d = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    e.acc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (or_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input exp_t e);
    bit done = 0;
    min_a    = a;
    sub_b    = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        e.acc = cyc + 1;
        sb.push_back(e);
        done = 1;
      end
      tick();
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    min_a    = DW'($urandom);
    sub_b    = DW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 0);
        end else begin
          if (!ov_prev) check("latency", cyc - sb[0].acc, NG);
          check("diff", 32'(diff), 32'(sb[0].d));
          check("borrow_out", 32'(borrow_out), 32'(sb[0].bo));
          check("ovf", 32'(ovf), 32'(sb[0].ov));
          if (!out_ready) check("stall_in_ready", 32'(in_ready), 0);
          else void'(sb.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  logic [DW-1:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

  initial begin
    logic [DW-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; min_a = '0; sub_b = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_borrow", 32'(borrow_out), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    tick();

    send(16'h0005, 16'h0003, mk(16'h0002, 1'b0, 1'b0)); drain();
    send(16'h0000, 16'h0001, mk(16'hFFFF, 1'b1, 1'b0)); drain();
`ifdef SUB_SAT_EN
    send(16'h8000, 16'h0001, mk(16'h8000, 1'b0, 1'b1)); drain();
    send(16'h7FFF, 16'hFFFF, mk(16'h7FFF, 1'b1, 1'b1)); drain();
`else
    send(16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b1)); drain();
    send(16'h7FFF, 16'hFFFF, mk(16'h8000, 1'b1, 1'b1)); drain();
`endif

    // Stall with out_ready low, then release together with a back-to-back accept.
    or_mode = 2;
    send(16'h1234, 16'h0034, mk(16'h1200, 1'b0, 1'b0));
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("stall_out_valid", 32'(out_valid), 1);
    repeat (10) tick();
    or_mode = 1;
    out_ready = 1'b1;
    send(16'h0010, 16'h0001, mk(16'h000F, 1'b0, 1'b0));
    drain();

    // Reset two cycles after accept abandons the operation.
    send(16'h1111, 16'h0101, model(16'h1111, 16'h0101));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_diff", 32'(diff), 0);
    check("abort_borrow", 32'(borrow_out), 0);
    check("abort_ovf", 32'(ovf), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    repeat (8) tick();
    check("abort_no_result", 32'(out_valid), 0);

    // Randomized traffic with random back-pressure and idle gaps.
    or_mode = 0;
    for (int k = 0; k < 200; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : DW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : DW'($urandom);
      send(ra, rb, model(ra, rb));
      if ($urandom_range(0, 2) == 0) tick();
    end
    drain();
    or_mode = 1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub.md
NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port min_a  input  DATA_W  minuend, two's-complement fixed point.
REQ-007 SHALL have port sub_b  input  DATA_W  subtrahend, two's-complement fixed point.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port diff  output  DATA_W  result min_a - sub_b.
REQ-011 SHALL have port borrow_out  output  1  unsigned borrow (inverted final carry).
REQ-012 SHALL have port ovf  output  1  signed overflow flag.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready = 1 in IDLE, and in DONE when out_ready = 1; 0 otherwise.
REQ-015 SHALL accept on in_valid & in_ready: latch min_a, ~sub_b, carry = 1, group index = 0, go to RUN.
REQ-016 In RUN SHALL process one 4-bit group per cycle, LSB group first, using group generate/propagate lookahead for the 4 internal carries, storing the group sum and carry-out for the next group.
REQ-017 SHALL leave RUN after the group index reaches DATA_W/4-1; out_valid SHALL rise exactly DATA_W/4 clock edges after the accept edge (4 for DATA_W=16).
REQ-018 SHALL hold diff, borrow_out, ovf and out_valid stable in DONE until out_valid & out_ready.
REQ-019 On out_valid & out_ready with no new accept SHALL return to IDLE; with simultaneous accept SHALL go directly to RUN (back-to-back, no bubble).
REQ-020 SHALL ignore in_valid whenever in_ready = 0; operand changes during RUN SHALL not affect the result.
REQ-021 SHALL compute ovf = (a[MSB] != b[MSB]) & (raw_diff[MSB] != a[MSB]).
REQ-022 SHALL compute borrow_out = ~carry out of the MSB group.
REQ-023 diff, borrow_out, ovf SHALL be registered outputs, updated only on the edge entering DONE.

Reset
REQ-024 rst SHALL force IDLE, out_valid = 0, diff = 0, borrow_out = 0, ovf = 0, group index = 0, on the next rising edge, regardless of state.
REQ-025 rst asserted mid-RUN SHALL abandon the operation with no result produced; in_ready = 1 on the first cycle after rst deasserts.
REQ-026 rst SHALL take priority over any handshake in the same cycle.

Configuration
REQ-027 Macro SUB_SAT_EN defined: on ovf = 1, diff SHALL saturate to 0x7FFF-equivalent (max positive) if a[MSB] = 0, else 0x8000-equivalent (min negative).
REQ-028 Macro SUB_SAT_EN undefined: diff SHALL be the wrapped modulo-2^DATA_W result; ovf still reported.

Verification
REQ-029 a=0x0005, b=0x0003 -> diff=0x0002, borrow_out=0, ovf=0, out_valid 4 edges after accept.
REQ-030 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1, ovf=0.
REQ-031 a=0x8000, b=0x0001 -> ovf=1; diff=0x8000 with SUB_SAT_EN, 0x7FFF without.
REQ-032 a=0x7FFF, b=0xFFFF -> ovf=1, borrow_out=1; diff=0x7FFF with SUB_SAT_EN, 0x8000 without.
REQ-033 out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 (a=0x0010, b=0x0001) -> back-to-back accept, next diff=0x000F.
REQ-034 rst pulsed 2 cycles after accept -> out_valid never asserts for that operation, all outputs 0, in_ready=1 after rst release.
